// File: rtl/m2m_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : m2m_pkg                                                   |
// | Purpose  : Shared types and constants for the memory-to-memory       |
// |            subtract sequencer (state encoding, default widths,       |
// |            per-element cycle count).                                 |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package m2m_pkg;

   // Default address / element-count width and data width
   localparam int M2M_AW = 8;
   localparam int M2M_DW = 8;

   // Each element costs: read A, read B, capture B, write result
   localparam int M2M_CYCLES_PER_ELEM = 4;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RDA  = 3'd1,
      ST_RDB  = 3'd2,
      ST_CAPB = 3'd3,
      ST_WR   = 3'd4,
      ST_DONE = 3'd5
   } state_e;

endpackage : m2m_pkg
`default_nettype wire

// File: rtl/sub_ovf_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sub_ovf_detect                                            |
// | Purpose  : Signed-overflow detector for a two's complement subtract  |
// |            (minuend - subtrahend). Only the sign bits matter:        |
// |            overflow happens when the operands differ in sign and the |
// |            result sign differs from the minuend sign.                |
// |            Instantiated only when M2M_SUB_OVF_DETECT_EN is defined.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module sub_ovf_detect (
   input  logic minuend_msb,
   input  logic subtrahend_msb,
   input  logic diff_msb,
   output logic ovf
);

   // Pure sign-bit comparison; no state
   always_comb begin
      ovf = (minuend_msb != subtrahend_msb) && (diff_msb != minuend_msb);
   end

endmodule : sub_ovf_detect
`default_nettype wire

// File: rtl/m2m_sub_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : m2m_sub_controller                                        |
// | Purpose  : Walks two source vectors in a single-port memory, feeds   |
// |            each operand pair to an external subtractor through the   |
// |            DOut2/DOut1 registers and writes SUBOut to a destination  |
// |            vector. Four cycles per element, one-cycle Done pulse.    |
// | Options  : M2M_SUB_OVF_DETECT_EN - enables the sticky signed         |
// |            overflow flag; otherwise OvfFlag is tied low.             |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module m2m_sub_controller
   import m2m_pkg::*;
#(
   parameter int AW = M2M_AW,
   parameter int DW = M2M_DW
) (
   input  logic          Clk,
   input  logic          nReset,
   input  logic          Start,
   input  logic [AW-1:0] SrcA,
   input  logic [AW-1:0] SrcB,
   input  logic [AW-1:0] Dst,
   input  logic [AW-1:0] Len,
   output logic [AW-1:0] MemAddr,
   output logic          MemRd,
   input  logic [DW-1:0] MemRdData,
   output logic          MemWr,
   output logic [DW-1:0] MemWrData,
   output logic [DW-1:0] DOut2,
   output logic [DW-1:0] DOut1,
   input  logic [DW-1:0] SUBOut,
   output logic          Busy,
   output logic          Done,
   output logic          OvfFlag
);

   state_e        state_q, state_d;
   logic [AW-1:0] srca_q, srca_d;
   logic [AW-1:0] srcb_q, srcb_d;
   logic [AW-1:0] dst_q, dst_d;
   logic [AW-1:0] len_q, len_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [AW-1:0] idx_inc;
   logic [AW-1:0] addr_q, addr_d;
   logic          rd_q, rd_d;
   logic          wr_q, wr_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [DW-1:0] dout2_q, dout2_d;
   logic [DW-1:0] dout1_q, dout1_d;

`ifdef M2M_SUB_OVF_DETECT_EN
   logic          ovf_q, ovf_d;
   logic          ovf_now;

   // Sign-bit overflow check on the operands currently presented to the subtractor
   sub_ovf_detect u_sub_ovf_detect (
      .minuend_msb    (dout2_q[DW-1]),
      .subtrahend_msb (dout1_q[DW-1]),
      .diff_msb       (SUBOut[DW-1]),
      .ovf            (ovf_now)
   );
`endif

   // Element index after the current write; wraps like the address space
   assign idx_inc = idx_q + {{(AW-1){1'b0}}, 1'b1};

   // Next-state, operand capture and registered-output decode
   always_comb begin
      state_d = state_q;
      srca_d  = srca_q;
      srcb_d  = srcb_q;
      dst_d   = dst_q;
      len_d   = len_q;
      idx_d   = idx_q;
      dout2_d = dout2_q;
      dout1_d = dout1_q;
`ifdef M2M_SUB_OVF_DETECT_EN
      ovf_d   = ovf_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               srca_d = SrcA;
               srcb_d = SrcB;
               dst_d  = Dst;
               len_d  = Len;
               idx_d  = '0;
`ifdef M2M_SUB_OVF_DETECT_EN
               ovf_d  = 1'b0;
`endif
               state_d = (Len == '0) ? ST_DONE : ST_RDA;
            end
         end
         ST_RDA: begin
            state_d = ST_RDB;
         end
         ST_RDB: begin
            // Read data returned here belongs to the A-side read of the previous cycle
            dout2_d = MemRdData;
            state_d = ST_CAPB;
         end
         ST_CAPB: begin
            dout1_d = MemRdData;
            state_d = ST_WR;
         end
         ST_WR: begin
`ifdef M2M_SUB_OVF_DETECT_EN
            if (ovf_now) begin
               ovf_d = 1'b1;
            end
`endif
            idx_d   = idx_inc;
            state_d = (idx_inc == len_q) ? ST_DONE : ST_RDA;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they are flop-driven in that state
      rd_d   = (state_d == ST_RDA) || (state_d == ST_RDB);
      wr_d   = (state_d == ST_WR);
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);

      case (state_d)
         ST_RDA:  addr_d = srca_d + idx_d;
         ST_RDB:  addr_d = srcb_d + idx_d;
         ST_WR:   addr_d = dst_d + idx_d;
         default: addr_d = addr_q;
      endcase
   end

   // All sequencer state and registered outputs; async reset clears everything at once
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state_q <= ST_IDLE;
         srca_q  <= '0;
         srcb_q  <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dout2_q <= '0;
         dout1_q <= '0;
`ifdef M2M_SUB_OVF_DETECT_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         srca_q  <= srca_d;
         srcb_q  <= srcb_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dout2_q <= dout2_d;
         dout1_q <= dout1_d;
`ifdef M2M_SUB_OVF_DETECT_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign MemAddr = addr_q;
   assign MemRd   = rd_q;
   assign MemWr   = wr_q;
   assign Busy    = busy_q;
   assign Done    = done_q;
   assign DOut2   = dout2_q;
   assign DOut1   = dout1_q;

   // The result only exists combinationally once DOut1 is loaded, so it is
   // forwarded during the write cycle and held at zero otherwise
   assign MemWrData = wr_q ? SUBOut : '0;

`ifdef M2M_SUB_OVF_DETECT_EN
   assign OvfFlag = ovf_q;
`else
   assign OvfFlag = 1'b0;
`endif

endmodule : m2m_sub_controller
`default_nettype wire

// File: tb/tb_m2m_sub_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_m2m_sub_controller                                     |
// | Purpose  : Directed self-checking bench for m2m_sub_controller with  |
// |            a behavioural memory and subtractor around the DUT.       |
// |            Honours M2M_SUB_OVF_DETECT_EN for the overflow flag.      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_m2m_sub_controller;

`ifdef M2M_SUB_OVF_DETECT_EN
   localparam logic EXP_OVF = 1'b1;
`else
   localparam logic EXP_OVF = 1'b0;
`endif
   localparam int BUDGET = 100;

   logic       Clk = 1'b0;
   logic       nReset;
   logic       Start;
   logic [7:0] SrcA, SrcB, Dst, Len;
   logic [7:0] MemAddr;
   logic       MemRd, MemWr;
   logic [7:0] MemRdData, MemWrData;
   logic [7:0] DOut2, DOut1, SUBOut;
   logic       Busy, Done, OvfFlag;

   logic [7:0] mem [0:255];
   logic       tb_we = 1'b0;
   logic [7:0] tb_wa = 8'h00, tb_wd = 8'h00;

   logic       rd_log  [0:BUDGET];
   logic       wr_log  [0:BUDGET];
   logic       ovf_log [0:BUDGET];
   logic [7:0] addr_log[0:BUDGET];
   int         rd_cnt, wr_cnt, overlap;

   int n_cmp = 0;
   int n_err = 0;

   always #5 Clk = ~Clk;

   m2m_sub_controller dut (
      .Clk(Clk), .nReset(nReset), .Start(Start),
      .SrcA(SrcA), .SrcB(SrcB), .Dst(Dst), .Len(Len),
      .MemAddr(MemAddr), .MemRd(MemRd), .MemRdData(MemRdData),
      .MemWr(MemWr), .MemWrData(MemWrData),
      .DOut2(DOut2), .DOut1(DOut1), .SUBOut(SUBOut),
      .Busy(Busy), .Done(Done), .OvfFlag(OvfFlag)
   );

   // External 8-bit subtractor
   assign SUBOut = DOut2 - DOut1;

   // Single-port memory: read data one cycle after MemRd, write commits on the edge
   always @(posedge Clk) begin
      if (tb_we)      mem[tb_wa] <= tb_wd;
      else if (MemWr) mem[MemAddr] <= MemWrData;
      if (MemRd)      MemRdData <= mem[MemAddr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      @(negedge Clk);
      tb_we = 1'b1; tb_wa = a; tb_wd = d;
      @(negedge Clk);
      tb_we = 1'b0;
   endtask

   // Issue one transfer and log per-cycle strobes; cyc = cycle of Done relative to the accepting edge
   task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d,
                      input logic [7:0] l, input bit inject, output int cyc);
      @(negedge Clk);
      SrcA = a; SrcB = b; Dst = d; Len = l; Start = 1'b1;
      cyc = -1; rd_cnt = 0; wr_cnt = 0; overlap = 0;
      @(posedge Clk);
      for (int c = 1; c <= BUDGET; c++) begin
         @(negedge Clk);
         if (c == 1) Start = 1'b0;
         if (inject && c == 3) begin
            Start = 1'b1; SrcA = 8'h00; Dst = 8'hA0; Len = 8'h01;
         end
         if (inject && c == 4) Start = 1'b0;
         rd_log[c] = MemRd; wr_log[c] = MemWr; ovf_log[c] = OvfFlag; addr_log[c] = MemAddr;
         if (MemRd) rd_cnt++;
         if (MemWr) wr_cnt++;
         if (MemRd && MemWr) overlap++;
         if (Done) begin
            cyc = c;
            break;
         end
      end
   endtask

   initial begin
      int         cyc;
      int         done_seen;
      int         wr_seen;
      logic [11:0] rd_seq, wr_seq;

      // ---- reset held with Start asserted ----
      nReset = 1'b0; Start = 1'b1;
      SrcA = 8'h11; SrcB = 8'h22; Dst = 8'h33; Len = 8'h04;
      repeat (3) @(negedge Clk);
      check("rst_addr", MemAddr, 8'h00);
      check("rst_rd", MemRd, 1'b0);
      check("rst_wr", MemWr, 1'b0);
      check("rst_wdata", MemWrData, 8'h00);
      check("rst_dout2", DOut2, 8'h00);
      check("rst_dout1", DOut1, 8'h00);
      check("rst_busy", Busy, 1'b0);
      check("rst_done", Done, 1'b0);
      check("rst_ovf", OvfFlag, 1'b0);
      Start = 1'b0;
      @(negedge Clk);
      nReset = 1'b1;

      // ---- single element, 0x7F - 0x00 ----
      poke(8'h10, 8'h7F);
      poke(8'h20, 8'h00);
      run(8'h10, 8'h20, 8'h30, 8'h01, 1'b0, cyc);
      check("single_done_cyc", cyc, 5);
      check("single_busy_c1", Busy, 1'b1);
      check("single_result", mem[8'h30], 8'h7F);
      check("single_ovf", OvfFlag, 1'b0);
      check("single_dout2_hold", DOut2, 8'h7F);
      check("single_dout1_hold", DOut1, 8'h00);
      @(negedge Clk);
      check("single_idle_busy", Busy, 1'b0);
      check("single_idle_done", Done, 1'b0);

      // ---- mixed signs, three elements ----
      poke(8'h40, 8'h1F); poke(8'h41, 8'hF0); poke(8'h42, 8'h10);
      poke(8'h50, 8'hF0); poke(8'h51, 8'h1C); poke(8'h52, 8'h10);
      run(8'h40, 8'h50, 8'h60, 8'h03, 1'b0, cyc);
      check("mixed_done_cyc", cyc, 13);
      check("mixed_r0", mem[8'h60], 8'h2F);
      check("mixed_r1", mem[8'h61], 8'hD4);
      check("mixed_r2", mem[8'h62], 8'h00);
      for (int c = 1; c <= 12; c++) begin
         rd_seq[c-1] = rd_log[c];
         wr_seq[c-1] = wr_log[c];
      end
      check("mixed_rd_seq", rd_seq, 12'h333);
      check("mixed_wr_seq", wr_seq, 12'h888);
      check("mixed_overlap", overlap, 0);
      check("mixed_wr_addr0", addr_log[4], 8'h60);
      check("mixed_rdb_addr2", addr_log[10], 8'h52);
      check("mixed_ovf", OvfFlag, 1'b0);

      // ---- signed overflow on both elements ----
      poke(8'h70, 8'h80); poke(8'h71, 8'h7F);
      poke(8'h78, 8'h01); poke(8'h79, 8'hFF);
      run(8'h70, 8'h78, 8'h7C, 8'h02, 1'b0, cyc);
      check("ovf_done_cyc", cyc, 9);
      check("ovf_r0", mem[8'h7C], 8'h7F);
      check("ovf_r1", mem[8'h7D], 8'h80);
      check("ovf_before_wr", ovf_log[4], 1'b0);
      check("ovf_after_wr1", ovf_log[5], EXP_OVF);
      check("ovf_at_done", OvfFlag, EXP_OVF);

      // ---- back-to-back restart clears the flag ----
      run(8'h40, 8'h50, 8'h68, 8'h03, 1'b0, cyc);
      check("b2b_done_cyc", cyc, 13);
      check("b2b_ovf_cleared", ovf_log[1], 1'b0);
      check("b2b_r1", mem[8'h69], 8'hD4);

      // ---- Len = 0 ----
      run(8'h40, 8'h50, 8'h68, 8'h00, 1'b0, cyc);
      check("len0_done_cyc", cyc, 1);
      check("len0_rd", rd_cnt, 0);
      check("len0_wr", wr_cnt, 0);
      check("len0_busy", Busy, 1'b1);

      // ---- source address wrap ----
      poke(8'hFF, 8'h05); poke(8'h00, 8'h09);
      poke(8'h80, 8'h01); poke(8'h81, 8'h02);
      run(8'hFF, 8'h80, 8'h90, 8'h02, 1'b0, cyc);
      check("wrap_done_cyc", cyc, 9);
      check("wrap_addr_first", addr_log[1], 8'hFF);
      check("wrap_addr_second", addr_log[5], 8'h00);
      check("wrap_r0", mem[8'h90], 8'h04);
      check("wrap_r1", mem[8'h91], 8'h07);

      // ---- Start and input changes while busy are ignored ----
      poke(8'hA0, 8'hEE);
      run(8'h40, 8'h50, 8'h98, 8'h02, 1'b1, cyc);
      check("busy_start_done_cyc", cyc, 9);
      check("busy_start_r0", mem[8'h98], 8'h2F);
      check("busy_start_r1", mem[8'h99], 8'hD4);
      check("busy_start_untouched", mem[8'hA0], 8'hEE);
      @(negedge Clk);
      check("busy_start_idle", Busy, 1'b0);

      // ---- reset during the write of element 2 of 4 ----
      poke(8'hC0, 8'h11); poke(8'hC1, 8'h22); poke(8'hC2, 8'h33); poke(8'hC3, 8'h44);
      poke(8'hC8, 8'h01); poke(8'hC9, 8'h01); poke(8'hCA, 8'h01); poke(8'hCB, 8'h01);
      poke(8'hB0, 8'hEE); poke(8'hB1, 8'hEE); poke(8'hB2, 8'hEE); poke(8'hB3, 8'hEE);
      @(negedge Clk);
      SrcA = 8'hC0; SrcB = 8'hC8; Dst = 8'hB0; Len = 8'h04; Start = 1'b1;
      @(posedge Clk);
      for (int c = 1; c <= 8; c++) begin
         @(negedge Clk);
         if (c == 1) Start = 1'b0;
      end
      check("rstmid_in_wr", MemWr, 1'b1);
      check("rstmid_wr_addr", MemAddr, 8'hB1);
      nReset = 1'b0;
      #1;
      check("rstmid_wr_cleared", MemWr, 1'b0);
      check("rstmid_busy_cleared", Busy, 1'b0);
      check("rstmid_dout2_cleared", DOut2, 8'h00);
      done_seen = 0; wr_seen = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge Clk);
         if (Done) done_seen++;
         if (MemWr) wr_seen++;
      end
      nReset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge Clk);
         if (Done) done_seen++;
         if (MemWr) wr_seen++;
      end
      check("rstmid_no_done", done_seen, 0);
      check("rstmid_no_write", wr_seen, 0);
      check("rstmid_first_kept", mem[8'hB0], 8'h10);
      check("rstmid_pending_dropped", mem[8'hB1], 8'hEE);

      run(8'hC0, 8'hC8, 8'hB0, 8'h04, 1'b0, cyc);
      check("rstmid_rerun_done_cyc", cyc, 17);
      check("rstmid_rerun_r1", mem[8'hB1], 8'h21);
      check("rstmid_rerun_r3", mem[8'hB3], 8'h43);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_m2m_sub_controller
`default_nettype wire

// File: doc/m2m_sub_controller.md
# m2m_sub_controller

Sequencer that sits directly upstream and downstream of the 8-bit `subtractor` in the memory-to-memory transfer datapath. On a start pulse it walks two source vectors in a single-port memory and loads each operand pair into the `DOut2`/`DOut1` registers that drive the subtractor. It then writes the resulting `SUBOut` to a destination vector in the same memory and reports completion, plus optional signed-overflow status.

## Interface
Parameters:
- `AW`, 8, memory address width; also the width of the element count.
- `DW`, 8, data width; must match the subtractor (8).

Ports:
- `Clk`  in  1  single system clock; all state changes on the rising edge.
- `nReset`  in  1  asynchronous, active-low reset.
- `Start`  in  1  request pulse; sampled only in IDLE.
- `SrcA`  in  AW  base address of the minuend vector.
- `SrcB`  in  AW  base address of the subtrahend vector.
- `Dst`  in  AW  base address of the result vector.
- `Len`  in  AW  element count; 0 means no-op.
- `MemAddr`  out  AW  shared memory address.
- `MemRd`  out  1  read strobe; `MemRdData` is valid in the next cycle.
- `MemRdData`  in  DW  read data.
- `MemWr`  out  1  write strobe.
- `MemWrData`  out  DW  write data.
- `DOut2`  out  DW  registered minuend to the subtractor.
- `DOut1`  out  DW  registered subtrahend to the subtractor.
- `SUBOut`  in  DW  subtractor result, combinational from `DOut2`/`DOut1`.
- `Busy`  out  1  high from the cycle after Start is accepted until DONE, inclusive.
- `Done`  out  1  one-cycle completion pulse.
- `OvfFlag`  out  1  sticky signed-overflow flag (see Configuration).

## Operation
- FSM states: IDLE, RDA, RDB, CAPB, WR, DONE.
- IDLE: when `Start`=1:
  - latch `SrcA`, `SrcB`, `Dst` and `Len`; clear index i and `OvfFlag`.
  - if `Len`=0, go to DONE; otherwise go to RDA.
- RDA: `MemRd`=1, `MemAddr`=SrcA+i. Next state RDB.
- RDB: `MemRd`=1, `MemAddr`=SrcB+i; `DOut2` <= `MemRdData`. Next state CAPB.
- CAPB: no memory access; `DOut1` <= `MemRdData`. Next state WR.
- WR: `MemWr`=1, `MemAddr`=Dst+i, `MemWrData`=`SUBOut`; evaluate overflow; i <= i+1.
  - if i+1 = `Len`, go to DONE; otherwise go to RDA.
- DONE: `Done`=1 for exactly one cycle, then IDLE.
- Address arithmetic is modulo 2^AW; wrap-around past the top of memory is legal and silent.
- Operands are two's complement. The controller performs no arithmetic on data; the result width stays DW and is written truncated exactly as `SUBOut` presents it.
- `Start` while not in IDLE is ignored. Input changes after acceptance have no effect on the current transfer.
- `MemRd` and `MemWr` are never high in the same cycle. Both are low in IDLE, CAPB and DONE.
- `DOut2` and `DOut1` hold their values between elements and after completion.

## Timing
- Reset values: state IDLE; `MemAddr`, `MemWrData`, `DOut2`, `DOut1` = 0; `MemRd`, `MemWr`, `Busy`, `Done`, `OvfFlag` = 0.
- Throughput: 4 cycles per element.
- Latency: if `Start` is sampled at edge k, `Done` is high in cycle k+4·Len+1. For `Len`=0, `Done` is high in cycle k+1.
- `MemWrData` and `MemAddr` are valid in the same cycle as `MemWr`. The memory commits the write on the following edge.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronous). No `Done` is produced and a pending write is not issued.
- Back-to-back: a new `Start` is accepted in the IDLE cycle that immediately follows DONE.

## Configuration
- Macro `M2M_SUB_OVF_DETECT_EN`.
- Defined:
  - in WR, overflow is (DOut2[DW-1] != DOut1[DW-1]) && (SUBOut[DW-1] != DOut2[DW-1]).
  - `OvfFlag` sets on any overflow in the transfer, stays set through DONE and IDLE, and clears on the next accepted `Start` or on reset.
- Undefined: no detection logic; `OvfFlag` is tied to 0. All other behaviour is identical.

## Structure
- Package `m2m_pkg` holds:
  - the state enum type.
  - the default `AW`/`DW` constants.
  - the per-element cycle-count constant (4).
- One sub-module: `sub_ovf_detect`, a combinational sign-bit comparator instantiated only under the macro.
- The subtractor is not instantiated inside this block; the top level wires `DOut2`/`DOut1`/`SUBOut` between the two.

## Test plan
- Reset: hold `nReset`=0 with `Start`=1 -> all outputs 0, no memory strobes.
- Single element, no overflow: mem[0x10]=0x7F, mem[0x20]=0x00, Len=1, Dst=0x30 -> mem[0x30]=0x7F, `Done` at k+5, `OvfFlag`=0.
- Mixed signs, three elements:
  - A={0x1F,0xF0,0x10}, B={0xF0,0x1C,0x10} -> Dst={0x2F,0xD4,0x00}.
  - Strobe sequence per element: RD, RD, idle, WR.
- Overflow (macro on): A={0x80,0x7F}, B={0x01,0xFF} -> Dst={0x7F,0x80}, `OvfFlag`=1 after the first WR and held. With the macro off, `OvfFlag` stays 0.
- Boundaries:
  - Len=0 -> `Done` at k+1, no strobes.
  - SrcA=0xFF, Len=2 -> second read from 0x00.
  - `Start` while `Busy` -> ignored.
- Reset mid-operation: deassert `nReset` during WR of element 2 of 4 -> no further writes, no `Done`. A fresh `Start` then completes normally.
